// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider: stall high 1+WIDTH cycles, done pulses the cycle after; cancel aborts.
// Optional DIV_EARLY_EXIT_EN: divide-by-zero or |dividend|<|divisor| skips the BUSY iterations.
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic             done_q;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted_d;
  logic             ge_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rmd_fix_d;

  assign sa    = signed_op & dividend[WIDTH-1];
  assign sb    = signed_op & divisor[WIDTH-1];
  assign a_mag = sa ? -dividend : dividend;
  assign b_mag = sb ? -divisor : divisor;

  // Partial remainder stays below the divisor, so the post-subtract value fits WIDTH bits.
  assign shifted_d = {rem_q, dvd_q[WIDTH-1]};
  assign ge_d      = shifted_d >= {1'b0, dvs_q};
  assign rem_d     = ge_d ? (shifted_d[WIDTH-1:0] - dvs_q) : shifted_d[WIDTH-1:0];
  assign dvd_d     = {dvd_q[WIDTH-2:0], ge_d};
  assign quo_fix_d = q_neg_q ? -dvd_d : dvd_d;
  assign rmd_fix_d = r_neg_q ? -rem_d : rem_d;

`ifdef DIV_EARLY_EXIT_EN
  logic             early_exit;
  logic [WIDTH-1:0] ee_quo;
  assign early_exit = (b_mag == '0) || (a_mag < b_mag);
  // Zero divisor yields all-ones magnitude; negated that is +1.
  assign ee_quo = (b_mag != '0) ? '0 : ((sa ^ sb) ? WIDTH'(1) : '1);
`endif

  assign stall     = ((state_q == IDLE) && start && !cancel) || (state_q == BUSY);
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      done_q  <= 1'b0;
    end else if (cancel) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            rem_q   <= '0;
            dvd_q   <= a_mag;
            dvs_q   <= b_mag;
            q_neg_q <= sa ^ sb;
            r_neg_q <= sa;
            cnt_q   <= CNT_W'(WIDTH - 1);
`ifdef DIV_EARLY_EXIT_EN
            if (early_exit) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quo_q   <= ee_quo;
              rmd_q   <= dividend;
            end else begin
              state_q <= BUSY;
            end
`else
            state_q <= BUSY;
`endif
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (cnt_q == '0) begin
            quo_q   <= quo_fix_d;
            rmd_q   <= rmd_fix_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
